// File: rtl/sar_adc_responder_pkg.sv
// sar_adc_responder_pkg: shared state encoding and default sizing for the SAR responder
package sar_adc_responder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam int N_DEF = 8;
  localparam int SETTLE_DEF = 1;
endpackage

// File: rtl/sar_datapath.sv
// sar_datapath: trial-code, result, bit-index and settle registers driven by controller commands
module sar_datapath
  import sar_adc_responder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         step_i,
  input  logic         cmp_i,
  output logic [N-1:0] dac_o,
  output logic [N-1:0] x_o,
  output logic         last_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  logic [N-1:0] dac_q, dac_d, x_q, x_d;
  logic [IW-1:0] i_q, i_d;
  logic [SW-1:0] s_q, s_d;
  logic resolve;
  assign resolve = step_i && (s_q == SW'(SETTLE - 1));
  assign last_o  = resolve && (i_q == '0);
  assign dac_o   = dac_q;
  assign x_o     = x_q;
  always_comb begin
    dac_d = dac_q;
    x_d   = x_q;
    i_d   = i_q;
    s_d   = s_q;
    if (start_i) begin
      dac_d        = '0;
      dac_d[N-1]   = 1'b1;
      i_d          = IW'(N - 1);
      s_d          = '0;
    end else if (step_i && !resolve) begin
      s_d = s_q + 1'b1;
    end else if (resolve) begin
      dac_d[i_q] = cmp_i;
      // bit 0 resolved: the completed code is captured as the result in the same edge
      if (i_q != '0) begin
        dac_d[i_q - 1'b1] = 1'b1;
        i_d               = i_q - 1'b1;
        s_d               = '0;
      end else begin
        x_d = dac_d;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dac_q <= '0;
      x_q   <= '0;
      i_q   <= '0;
      s_q   <= '0;
    end else begin
      dac_q <= dac_d;
      x_q   <= x_d;
      i_q   <= i_d;
      s_q   <= s_d;
    end
  end
endmodule

// File: rtl/sar_adc_responder.sv
// sar_adc_responder: soc/eoc four-phase responder running an N-bit successive approximation
module sar_adc_responder
  import sar_adc_responder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic         cmp,
  output logic         eoc,
  output logic [N-1:0] x,
  output logic [N-1:0] dac
);
  state_e state_q, state_d;
  logic start, step, last;
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        start   = soc;
        state_d = soc ? CONV : IDLE;
      end
      CONV: begin
        step    = 1'b1;
        state_d = last ? DONE : CONV;
      end
      DONE:    state_d = soc ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state_q <= IDLE;
    else         state_q <= state_d;
  end
  // eoc decodes straight from the state register, so reset raises it without a clock
  assign eoc = (state_q == IDLE);
  sar_datapath #(.N(N), .SETTLE(SETTLE)) u_dp (
    .clk_i  (clock),
    .rst_ni (reset_),
    .start_i(start),
    .step_i (step),
    .cmp_i  (cmp),
    .dac_o  (dac),
    .x_o    (x),
    .last_o (last)
  );
endmodule

// File: tb/tb_sar_adc_responder.sv
// tb_sar_adc_responder: directed scoreboard bench with analog comparator models for SETTLE=1 and SETTLE=3
module tb_sar_adc_responder;
  logic clock = 1'b0;
  logic reset_ = 1'b0;
  logic soc = 1'b0, soc3 = 1'b0;
  logic [7:0] vin = 8'h00, vin3 = 8'h00;
  logic cmp, cmp3, eoc, eoc3;
  logic [7:0] x, dac, x3, dac3;
  logic [7:0] sb[$];
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  assign cmp  = (vin >= dac);
  assign cmp3 = (vin3 >= dac3);
  sar_adc_responder #(.N(8), .SETTLE(1)) u_dut (
    .clock(clock), .reset_(reset_), .soc(soc), .cmp(cmp), .eoc(eoc), .x(x), .dac(dac)
  );
  sar_adc_responder #(.N(8), .SETTLE(3)) u_dut3 (
    .clock(clock), .reset_(reset_), .soc(soc3), .cmp(cmp3), .eoc(eoc3), .x(x3), .dac(dac3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  function automatic logic [7:0] trial(input logic [7:0] v, input int r);
    logic [7:0] m;
    m = 8'hFF;
    if (r >= 8) return v;
    m = m << (8 - r);
    return (v & m) | (8'h80 >> r);
  endfunction
  function automatic logic [7:0] pop_exp();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
      return 8'h00;
    end
    return sb.pop_front();
  endfunction
  task automatic run_conv(input logic [7:0] v, input int hold, input bit tog);
    int last;
    logic [7:0] prev, exp_x;
    prev = x;
    vin  = v;
    sb.push_back(v);
    last = (hold + 1 > 9) ? hold + 1 : 9;
    @(negedge clock) soc = 1'b1;
    @(posedge clock); #1;
    chk("start_eoc", eoc, 0);
    chk("start_dac", dac, 8'h80);
    for (int e = 1; e <= last; e++) begin
      @(negedge clock) soc = (e <= hold) && (!tog || e >= 8 || (e % 2 == 1));
      @(posedge clock); #1;
      if (e < 8) begin
        chk("trial_dac", dac, trial(v, e));
        chk("x_hold", x, prev);
      end else if (e == 8) begin
        exp_x = pop_exp();
        chk("result_x", x, exp_x);
        chk("dac_final", dac, exp_x);
      end else begin
        chk("x_stable", x, v);
      end
      chk("eoc", eoc, (e == last));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] exp_x;
    #12;
    chk("rst_eoc", eoc, 1);
    chk("rst_x", x, 0);
    chk("rst_dac", dac, 0);
    chk("rst_eoc3", eoc3, 1);
    @(negedge clock) reset_ = 1'b1;
    run_conv(8'hA5, 0, 1'b0);
    run_conv(8'h00, 0, 1'b0);
    run_conv(8'hFF, 0, 1'b0);
    run_conv(8'h3C, 28, 1'b0);
    run_conv(8'h69, 10, 1'b1);
    vin = 8'h5A;
    @(negedge clock) soc = 1'b1;
    @(negedge clock) soc = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset_ = 1'b0;
    #1;
    chk("abort_eoc", eoc, 1);
    chk("abort_x", x, 0);
    chk("abort_dac", dac, 0);
    @(negedge clock) reset_ = 1'b1;
    run_conv(8'h5A, 0, 1'b0);
    vin3 = 8'hC3;
    sb.push_back(8'hC3);
    @(negedge clock) soc3 = 1'b1;
    @(posedge clock); #1;
    chk("s3_start_dac", dac3, 8'h80);
    @(negedge clock) soc3 = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      if (e > 1) @(posedge clock);
      else @(posedge clock);
      #1;
      if (e < 24) begin
        chk("s3_trial_dac", dac3, trial(8'hC3, e / 3));
        chk("s3_x_hold", x3, 0);
      end else if (e == 24) begin
        exp_x = pop_exp();
        chk("s3_result_x", x3, exp_x);
        chk("s3_dac_final", dac3, exp_x);
      end
      chk("s3_eoc", eoc3, (e == 25));
    end
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
